// File: rtl/axil_cfg_master.sv
// axil_cfg_master: turns single-word register read/write commands from a
// valid/ready stream into one AXI4-Lite transaction each, one outstanding at
// a time, and returns BRESP/RRESP (plus read data) on a response stream.
// A saturating counter tracks every non-OKAY response.
module axil_cfg_master #(
  parameter int         ADDR_WIDTH = 40,
  parameter int         DATA_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] PROT       = 3'b000,
  parameter int         ERR_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  busy,
  // AXI4-Lite write address / data / response
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  // AXI4-Lite read address / data
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  // Low address bits below the word size are forced to zero so every
  // access is word aligned on the bus.
  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_KEEP =
    ~ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WR_B  = 3'd2,
    RD_AR = 3'd3,
    RD_R  = 3'd4,
    RSP   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;

  // Saturating increment of the error counter for a non-OKAY response.
  function automatic logic [ERR_CNT_W-1:0] err_next(
    input logic [ERR_CNT_W-1:0] cnt,
    input logic [1:0]           resp
  );
    logic [ERR_CNT_W-1:0] res;
    res = cnt;
    if ((resp != 2'b00) && (cnt != {ERR_CNT_W{1'b1}})) begin
      res = cnt + ERR_CNT_W'(1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  // Next-state and next-output decode; handshake-facing outputs are
  // registered from the next state so they line up with state entry.
  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    araddr_d    = araddr_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr & ADDR_KEEP;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            araddr_d  = cmd_addr & ADDR_KEEP;
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        // AW and W retire independently; move on once both are done,
        // including when both complete in this very cycle.
        if (awvalid_q && m_axil_awready) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (wvalid_q && m_axil_wready) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
          state_d = WR_B;
        end else begin
          state_d = WR;
        end
      end
      WR_B: begin
        if (m_axil_bvalid) begin
          rsp_resp_d  = m_axil_bresp;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          err_d       = err_next(err_q, m_axil_bresp);
          state_d     = RSP;
        end else begin
          state_d = WR_B;
        end
      end
      RD_AR: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_R;
        end else begin
          state_d = RD_AR;
        end
      end
      RD_R: begin
        if (m_axil_rvalid) begin
          rsp_resp_d  = m_axil_rresp;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axil_rdata;
          err_d       = err_next(err_q, m_axil_rresp);
          state_d     = RSP;
        end else begin
          state_d = RD_R;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
      end
    endcase

    bready_d    = (state_d == WR_B);
    rready_d    = (state_d == RD_R);
    rsp_valid_d = (state_d == RSP);
  end

  // State and registered-output storage; reset aborts any transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      araddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      araddr_q    <= araddr_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign err_count      = err_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = PROT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = PROT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Bench for axil_cfg_master: a table of directed commands with a scripted
// AXI4-Lite slave (per-channel wait states), plus hand sequences for
// back-pressure and reset in the middle of a read. A second instance with a
// 2-bit error counter shares all inputs to cover counter saturation.
module tb_axil_cfg_master;

  logic        clk;
  logic        rstn;
  logic        cmd_valid, cmd_write;
  logic [39:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_ready;
  logic        m_axil_awready, m_axil_wready, m_axil_bvalid;
  logic        m_axil_arready, m_axil_rvalid;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic [31:0] m_axil_rdata;

  logic        cmd_ready, rsp_valid, rsp_write, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_count;
  logic [39:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;

  logic        d2_cmd_ready, d2_rsp_valid, d2_rsp_write, d2_busy;
  logic [31:0] d2_rsp_rdata, d2_wdata;
  logic [1:0]  d2_rsp_resp, err_count2;
  logic [39:0] d2_awaddr, d2_araddr;
  logic [2:0]  d2_awprot, d2_arprot;
  logic        d2_awvalid, d2_wvalid, d2_bready, d2_arvalid, d2_rready;
  logic [3:0]  d2_wstrb;

  int checks = 0;
  int errors = 0;

  axil_cfg_master dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count), .busy(busy),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  axil_cfg_master #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(d2_rsp_write),
    .rsp_rdata(d2_rsp_rdata), .rsp_resp(d2_rsp_resp), .err_count(err_count2), .busy(d2_busy),
    .m_axil_awaddr(d2_awaddr), .m_axil_awprot(d2_awprot),
    .m_axil_awvalid(d2_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(d2_wdata), .m_axil_wstrb(d2_wstrb),
    .m_axil_wvalid(d2_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(d2_bready),
    .m_axil_araddr(d2_araddr), .m_axil_arprot(d2_arprot),
    .m_axil_arvalid(d2_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(d2_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [39:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        stray;
    int          rsp_dly;
    logic [39:0] exp_addr;
    int          exp_lat;
    int          exp_err;
  } vec_t;

  vec_t vecs[10];
  vec_t post_rst_vec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] sat2(input int e);
    return (e > 3) ? 2'd3 : 2'(e);
  endfunction

  task automatic slave_idle();
    m_axil_awready = 1'b0; m_axil_wready = 1'b0;
    m_axil_bvalid  = 1'b0; m_axil_bresp  = 2'b00;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
    m_axil_rresp   = 2'b00; m_axil_rdata = 32'h0;
  endtask

  // Issue one command at the current negedge (DUT idle) and play the slave.
  task automatic run_vec(input int idx, input vec_t v);
    int c, viol, hold_viol;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit got, aw_done, w_done, ar_done, aw_hs, w_hs, ar_hs;
    c = 0; viol = 0; hold_viol = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    got = 1'b0; aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
    aw_hs = 1'b0; w_hs = 1'b0; ar_hs = 1'b0;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.strb;
    chk($sformatf("v%0d cmd_ready", idx), 64'(cmd_ready), 64'd1);
    @(negedge clk);
    c = 1;
    cmd_valid = 1'b0; cmd_addr = 40'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    while (!got && c < 100) begin
      aw_done |= aw_hs; w_done |= w_hs; ar_done |= ar_hs;
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (v.wr) begin
          if (m_axil_awvalid == aw_done) viol++;
          if (m_axil_wvalid == w_done) viol++;
          if (m_axil_bready != (aw_done && w_done)) viol++;
          if (m_axil_arvalid || m_axil_rready) viol++;
        end else begin
          if (m_axil_arvalid == ar_done) viol++;
          if (m_axil_rready != ar_done) viol++;
          if (m_axil_awvalid || m_axil_wvalid || m_axil_bready) viol++;
        end
        if (cmd_ready || !busy) viol++;
        m_axil_awready = m_axil_awvalid && (aw_cnt >= v.aw_dly);
        if (m_axil_awvalid) aw_cnt++;
        aw_hs = m_axil_awvalid && m_axil_awready;
        if (aw_hs) begin
          chk($sformatf("v%0d awaddr", idx), 64'(m_axil_awaddr), 64'(v.exp_addr));
          chk($sformatf("v%0d awprot", idx), 64'(m_axil_awprot), 64'd0);
        end
        m_axil_wready = m_axil_wvalid && (w_cnt >= v.w_dly);
        if (m_axil_wvalid) w_cnt++;
        w_hs = m_axil_wvalid && m_axil_wready;
        if (w_hs) begin
          chk($sformatf("v%0d wdata", idx), 64'(m_axil_wdata), 64'(v.wdata));
          chk($sformatf("v%0d wstrb", idx), 64'(m_axil_wstrb), 64'(v.strb));
        end
        if (v.wr && aw_done && w_done) begin
          m_axil_bvalid = (b_cnt >= v.b_dly); b_cnt++; m_axil_bresp = v.resp;
        end else begin
          m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
        end
        if (!v.wr && v.stray) begin
          m_axil_bvalid = 1'b1; m_axil_bresp = 2'b10;
        end
        m_axil_arready = m_axil_arvalid && (ar_cnt >= v.ar_dly);
        if (m_axil_arvalid) ar_cnt++;
        ar_hs = m_axil_arvalid && m_axil_arready;
        if (ar_hs) begin
          chk($sformatf("v%0d araddr", idx), 64'(m_axil_araddr), 64'(v.exp_addr));
          chk($sformatf("v%0d arprot", idx), 64'(m_axil_arprot), 64'd0);
        end
        if (!v.wr && ar_done) begin
          m_axil_rvalid = (r_cnt >= v.r_dly); r_cnt++;
          m_axil_rdata = v.rdata; m_axil_rresp = v.resp;
        end else begin
          m_axil_rvalid = 1'b0; m_axil_rdata = 32'hBAD0BAD0; m_axil_rresp = 2'b11;
        end
        @(negedge clk);
        c++;
      end
    end
    slave_idle();
    chk($sformatf("v%0d rsp_valid seen", idx), 64'(got), 64'd1);
    if (got) begin
      chk($sformatf("v%0d latency", idx), 64'(c), 64'(v.exp_lat));
      chk($sformatf("v%0d rsp_write", idx), 64'(rsp_write), 64'(v.wr));
      chk($sformatf("v%0d rsp_rdata", idx), 64'(rsp_rdata), v.wr ? 64'd0 : 64'(v.rdata));
      chk($sformatf("v%0d rsp_resp", idx), 64'(rsp_resp), 64'(v.resp));
      chk($sformatf("v%0d err_count", idx), 64'(err_count), 64'(v.exp_err));
      chk($sformatf("v%0d err_count2", idx), 64'(err_count2), 64'(sat2(v.exp_err)));
      chk($sformatf("v%0d protocol", idx), 64'(viol), 64'd0);
      for (int k = 0; k < v.rsp_dly; k++) begin
        @(negedge clk);
        if (!rsp_valid || cmd_ready || rsp_rdata !== (v.wr ? 32'h0 : v.rdata)
            || rsp_resp !== v.resp) hold_viol++;
      end
      chk($sformatf("v%0d rsp hold", idx), 64'(hold_viol), 64'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk($sformatf("v%0d rsp_valid drop", idx), 64'(rsp_valid), 64'd0);
      chk($sformatf("v%0d idle", idx), 64'({cmd_ready, busy}), 64'b10);
    end
  endtask

  initial begin
    int n_aw, k;
    bit seen;
    //            wr    addr            wdata          strb aw w  b  ar r  rdata          resp   st   rd exp_addr        lat err
    vecs[0] = '{1'b1, 40'h10,  32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0,        2'b00, 1'b0, 0, 40'h10,  3,  0};
    vecs[1] = '{1'b1, 40'h104, 32'hA5A5A5A5, 4'h3, 3, 0, 0, 0, 0, 32'h0,        2'b00, 1'b0, 1, 40'h104, 6,  0};
    vecs[2] = '{1'b1, 40'h207, 32'h01020304, 4'hC, 0, 2, 1, 0, 0, 32'h0,        2'b00, 1'b0, 0, 40'h204, 6,  0};
    vecs[3] = '{1'b0, 40'h23,  32'h0,        4'h0, 0, 0, 0, 2, 5, 32'h12345678, 2'b00, 1'b0, 3, 40'h20,  10, 0};
    vecs[4] = '{1'b0, 40'h40,  32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 2'b10, 1'b1, 0, 40'h40,  3,  1};
    vecs[5] = '{1'b1, 40'h44,  32'h11223344, 4'hF, 0, 0, 0, 0, 0, 32'h0,        2'b11, 1'b0, 0, 40'h44,  3,  2};
    vecs[6] = '{1'b0, 40'h48,  32'h0,        4'h0, 0, 0, 0, 1, 0, 32'h55AA55AA, 2'b00, 1'b0, 0, 40'h48,  4,  2};
    vecs[7] = '{1'b1, 40'h4C,  32'h0BADF00D, 4'h1, 1, 1, 0, 0, 0, 32'h0,        2'b10, 1'b0, 0, 40'h4C,  4,  3};
    vecs[8] = '{1'b0, 40'h51,  32'h0,        4'h0, 0, 0, 0, 0, 2, 32'h87654321, 2'b11, 1'b0, 2, 40'h50,  5,  4};
    vecs[9] = '{1'b1, 40'h5E,  32'hFEEDFACE, 4'h8, 2, 2, 2, 0, 0, 32'h0,        2'b10, 1'b0, 0, 40'h5C,  7,  5};
    post_rst_vec = '{1'b1, 40'hFF_FFFF_FFFF, 32'h600DCAFE, 4'hF, 0, 0, 0, 0, 0, 32'h0,
                     2'b00, 1'b0, 0, 40'hFF_FFFF_FFFC, 3, 0};

    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 40'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
    slave_idle();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Reset state
    chk("reset cmd_ready/busy", 64'({cmd_ready, busy}), 64'b10);
    chk("reset valids/readies", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
        m_axil_bready, m_axil_rready, rsp_valid}), 64'd0);
    chk("reset err_count", 64'(err_count), 64'd0);
    chk("reset addr/data", 64'({m_axil_awaddr, m_axil_wdata[23:0]}), 64'd0);
    chk("reset rsp payload", 64'({rsp_rdata, rsp_resp, rsp_write}), 64'd0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Back-pressure: cmd_valid held, rsp_ready low, zero-wait slave.
    m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 40'h80; cmd_wdata = 32'h13579BDF; cmd_wstrb = 4'hF;
    n_aw = 0;
    for (int c = 0; c < 12; c++) begin
      if (m_axil_awvalid && m_axil_awready) n_aw++;
      @(negedge clk);
    end
    chk("bp single AW", 64'(n_aw), 64'd1);
    chk("bp rsp_valid held", 64'({rsp_valid, cmd_ready}), 64'b10);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp accept after rsp", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp second AW", 64'({m_axil_awvalid, busy}), 64'b11);
    seen = 1'b0;
    for (k = 0; k < 10 && !seen; k++) begin
      if (rsp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    chk("bp second rsp", 64'(seen), 64'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    slave_idle();
    chk("bp err_count", 64'(err_count), 64'd5);

    // Reset while waiting in RD_R.
    m_axil_arready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 40'h30;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 10 && !seen; k++) begin
      if (m_axil_rready) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rst reached RD_R", 64'(seen), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst drops valids", 64'({m_axil_rready, m_axil_arvalid, rsp_valid}), 64'd0);
    chk("rst idle", 64'({cmd_ready, busy}), 64'b10);
    chk("rst err_count", 64'(err_count), 64'd0);
    m_axil_arready = 1'b0;
    m_axil_rvalid = 1'b1; m_axil_rdata = 32'hFFFFFFFF; m_axil_rresp = 2'b10;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst no response", 64'({rsp_valid, m_axil_rready, cmd_ready}), 64'b001);
    chk("rst stray r ignored", 64'(err_count), 64'd0);
    slave_idle();

    run_vec(10, post_rst_vec);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_cfg_master.md
# axil_cfg_master

AXI4-Lite initiator that drives the accelerator's `s_axil_*` configuration/control slave port from a simple valid/ready command stream. It sits between the host-side command source (firmware shim or bench sequencer) and the controller's register file. It turns each single-word register read or write into one AXI4-Lite transaction and returns the response on a valid/ready response stream. At most one transaction is outstanding at a time; a saturating error counter tracks non-OKAY responses.

## Interface
- `ADDR_WIDTH`, 40, AXI4-Lite address width.
- `DATA_WIDTH`, 32, data width; must be 32 or 64.
- `STRB_WIDTH`, `DATA_WIDTH/8`, write strobe width.
- `PROT`, 3'b000, constant driven on `awprot`/`arprot`.
- `ERR_CNT_W`, 16, width of the error counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `cmd_valid` / `cmd_ready`  in / out  1 / 1  command handshake.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  byte address.
- `cmd_wdata`  in  DATA_WIDTH  write data.
- `cmd_wstrb`  in  STRB_WIDTH  write byte enables.
- `rsp_valid` / `rsp_ready`  out / in  1 / 1  response handshake.
- `rsp_write`  out  1  echo of `cmd_write`.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes.
- `rsp_resp`  out  2  captured BRESP/RRESP.
- `err_count`  out  ERR_CNT_W  saturating count of responses with resp != 2'b00.
- `busy`  out  1  high whenever the state is not IDLE.
- `m_axil_awaddr`, `awprot`, `awvalid`, `awready`, `wdata`, `wstrb`, `wvalid`, `wready`, `bresp`, `bvalid`, `bready`, `araddr`, `arprot`, `arvalid`, `arready`, `rdata`, `rresp`, `rvalid`, `rready`  standard AXI4-Lite master-side directions and widths.

## Operation
- States: IDLE, WR (AW/W issue), WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid`, register the command, clear address bits `[$clog2(STRB_WIDTH)-1:0]` to 0, and go to WR or RD_AR.
- WR:
  - `awvalid` and `wvalid` rise together on state entry.
  - Each drops independently on the cycle after its own handshake completes.
  - Leave for WR_B once both handshakes are done, including the case where both complete in the same cycle.
  - Payload stays stable while valid is high.
- WR_B:
  - `bready` = 1.
  - On `bvalid`, capture `bresp`, set `rsp_write` = 1 and `rsp_rdata` = 0, go to RSP.
- RD_AR: `arvalid` = 1 until `arready`, then go to RD_R.
- RD_R:
  - `rready` = 1.
  - On `rvalid`, capture `rdata`/`rresp`, set `rsp_write` = 0, go to RSP.
- RSP:
  - `rsp_valid` = 1, payload stable.
  - On `rsp_ready`, go to IDLE.
- `bready`/`rready` are 0 outside WR_B/RD_R; a stray `bvalid`/`rvalid` there is ignored.
- `err_count` increments in the capture cycle when resp != 0 and saturates at all-ones.
- No timeout: a slave that never responds holds the block in WR_B/RD_R until reset.

## Timing
- All outputs are registered except `cmd_ready` and `busy`, which decode the state.
- Reset values:
  - all `*valid` and `*ready` outputs 0, except `cmd_ready` = 1;
  - addresses, data, strobes, `rsp_*` and `err_count` all 0;
  - state IDLE.
- Reset assertion mid-transaction returns the block to IDLE and drops all valids asynchronously; no response is produced for the aborted command.
- Write with zero-wait slave: command accepted in cycle N, AW/W handshake in N+1, B handshake in N+2, `rsp_valid` in N+3.
- Read with zero-wait slave: command accepted in N, AR in N+1, R in N+2, `rsp_valid` in N+3.
- Throughput at best: one command every 4 cycles. With `rsp_ready` held high, a new command is accepted in the cycle after the RSP handshake.
- `cmd_ready` is 0 from the cycle after acceptance until the state returns to IDLE, so back-to-back `cmd_valid` is stalled rather than dropped.

## Test plan
- **Write, zero-wait slave:** write addr 0x10, data 0xDEADBEEF, strb 0xF → AW/W in N+1 with `awaddr` = 0x10; `rsp_valid` in N+3 with `rsp_resp` = 0, `rsp_write` = 1; `err_count` = 0.
- **Skewed write handshakes:** `awready` delayed 3 cycles, `wready` immediate → `wvalid` drops after cycle N+1; `awvalid` holds to N+4; `bready` rises only after both complete.
- **Read with wait states:** read addr 0x23, `arready` after 2 cycles, `rvalid` after 5 with data 0x12345678 → `araddr` = 0x20; `rsp_rdata` = 0x12345678; `rsp_valid` held until `rsp_ready`.
- **Error responses:** three commands answered with SLVERR/DECERR/OKAY → `err_count` = 2; with `ERR_CNT_W` = 2, five errors give `err_count` = 3 (saturated).
- **Back-pressure and stalls:** `cmd_valid` held continuously with `rsp_ready` low for 10 cycles → exactly one AXI transaction issued; the second command is accepted one cycle after the RSP handshake.
- **Reset mid-operation:** deassert `rstn` while in RD_R → `rready`/`arvalid` go to 0 immediately, no `rsp_valid`; after release, `cmd_ready` = 1 and the next command completes normally.
